// File: rtl/pfb_pkg.sv
// Shared widths, read latency, unity weight and FSM state encoding for the PFB weight multiplier.
package pfb_pkg;

  localparam int unsigned DATA_W   = 14;
  localparam int unsigned WEIGHT_W = 14;
  localparam int unsigned PROD_W   = 28;
  localparam int unsigned ADDR_W   = 12;
  localparam int unsigned RD_LAT   = 2;

  localparam logic signed [WEIGHT_W-1:0] UNITY_WEIGHT = 14'sd8191;

  typedef logic [0:0] state_t;

  localparam state_t StIdle = 1'b0;
  localparam state_t StRun  = 1'b1;

  // Operands are sign-extended first so the 28-bit product is exact (no wrap at -8192*-8192).
  function automatic logic signed [PROD_W-1:0] mul_full(input logic signed [DATA_W-1:0]   a,
                                                        input logic signed [WEIGHT_W-1:0] b);
    logic signed [PROD_W-1:0] a_ext;
    logic signed [PROD_W-1:0] b_ext;
    a_ext = PROD_W'(a);
    b_ext = PROD_W'(b);
    return a_ext * b_ext;
  endfunction

endpackage

// File: rtl/pfb_tag_pipe.sv
// Fixed-depth delay line that keeps per-product tags aligned with the weight SRAM read data.
module pfb_tag_pipe
  import pfb_pkg::*;
#(
  parameter int unsigned Width = 1,
  parameter int unsigned Depth = RD_LAT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] stage_q [Depth];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d;
      for (int unsigned i = 1; i < Depth; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q = stage_q[Depth-1];

endmodule

// File: rtl/pfb_weight_mult.sv
// Polyphase filter-bank weight multiplier: each accepted sample is multiplied by NTAPS SRAM weights.
// Optional feature macro PFB_WEIGHT_BYPASS_EN adds weight_bypass, forcing UNITY_WEIGHT per product.
module pfb_weight_mult
  import pfb_pkg::*;
#(
  parameter int unsigned NFFT  = 1024,
  parameter int unsigned NTAPS = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic signed [DATA_W-1:0]   s_data,
  input  logic                       resync,
`ifdef PFB_WEIGHT_BYPASS_EN
  input  logic                       weight_bypass,
`endif
  output logic [ADDR_W-1:0]          w_raddr,
  input  logic signed [WEIGHT_W-1:0] w_rdata,
  output logic                       m_valid,
  output logic signed [PROD_W-1:0]   m_data,
  output logic [$clog2(NTAPS)-1:0]   m_tap,
  output logic [$clog2(NFFT)-1:0]    m_idx,
  output logic                       m_last
);

  localparam int unsigned TapW = $clog2(NTAPS);
  localparam int unsigned IdxW = $clog2(NFFT);

  state_t                    state_q, state_d;
  logic [TapW-1:0]           tap_q, tap_d;
  logic [IdxW-1:0]           idx_q, idx_d;
  logic signed [DATA_W-1:0]  sample_q;
  logic [ADDR_W-1:0]         raddr_q;

  logic in_run;
  logic last_tap;
  logic last_issue;
  logic accept;

  assign in_run     = (state_q == StRun);
  assign last_tap   = (tap_q == TapW'(NTAPS - 1));
  assign last_issue = in_run & last_tap & (idx_q == IdxW'(NFFT - 1));

  // Gating with reset keeps s_ready low while the reset is still asserted.
  assign s_ready = ~reset & ~resync & (~in_run | last_tap);
  assign accept  = s_valid & s_ready;

  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    idx_d   = idx_q;
    if (in_run) begin
      tap_d = tap_q + TapW'(1);
      if (last_tap) begin
        idx_d = idx_q + IdxW'(1);
        if (!accept) begin
          state_d = StIdle;
        end
      end
    end
    if (accept) begin
      state_d = StRun;
      tap_d   = '0;
    end
    if (resync) begin
      state_d = StIdle;
      tap_d   = '0;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      tap_q    <= '0;
      idx_q    <= '0;
      sample_q <= '0;
      raddr_q  <= '0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      idx_q   <= idx_d;
      if (accept) begin
        sample_q <= s_data;
      end
      if (in_run) begin
        raddr_q <= {tap_q, idx_q};
      end
    end
  end

  // Live address while running; the registered copy holds the last one across idle cycles.
  assign w_raddr = in_run ? {tap_q, idx_q} : raddr_q;

  logic                      t_valid;
  logic                      t_last;
  logic signed [DATA_W-1:0]  t_sample;
  logic [TapW-1:0]           t_tap;
  logic [IdxW-1:0]           t_idx;
  logic signed [WEIGHT_W-1:0] weight;

`ifdef PFB_WEIGHT_BYPASS_EN
  localparam int unsigned TagW = 3 + DATA_W + TapW + IdxW;

  logic [TagW-1:0] tag_in, tag_out;
  logic            t_byp;

  assign tag_in = {in_run, last_issue, weight_bypass, sample_q, tap_q, idx_q};
  assign {t_valid, t_last, t_byp, t_sample, t_tap, t_idx} = tag_out;
  assign weight = t_byp ? UNITY_WEIGHT : w_rdata;
`else
  localparam int unsigned TagW = 2 + DATA_W + TapW + IdxW;

  logic [TagW-1:0] tag_in, tag_out;

  assign tag_in = {in_run, last_issue, sample_q, tap_q, idx_q};
  assign {t_valid, t_last, t_sample, t_tap, t_idx} = tag_out;
  assign weight = w_rdata;
`endif

  pfb_tag_pipe #(
    .Width (TagW),
    .Depth (RD_LAT)
  ) u_tag_pipe (
    .clk   (clk),
    .reset (reset),
    .d     (tag_in),
    .q     (tag_out)
  );

  // Output stage adds the one register after the SRAM data, giving RD_LAT+1 total latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_tap   <= '0;
      m_idx   <= '0;
      m_last  <= 1'b0;
    end else begin
      m_valid <= t_valid;
      m_data  <= t_valid ? mul_full(t_sample, weight) : '0;
      m_tap   <= t_valid ? t_tap : '0;
      m_idx   <= t_valid ? t_idx : '0;
      m_last  <= t_valid & t_last;
    end
  end

endmodule

// File: tb/tb_pfb_weight_mult.sv
// Directed bench for pfb_weight_mult: vector table plus resync, reset and streaming sequences.
module tb_pfb_weight_mult;

  logic               clk = 1'b0;
  logic               reset;
  logic               s_valid;
  logic               s_ready;
  logic signed [13:0] s_data;
  logic               resync;
  logic [11:0]        w_raddr;
  logic signed [13:0] w_rdata;
  logic               m_valid;
  logic signed [27:0] m_data;
  logic [1:0]         m_tap;
  logic [9:0]         m_idx;
  logic               m_last;
`ifdef PFB_WEIGHT_BYPASS_EN
  logic               weight_bypass;
`endif

  pfb_weight_mult #(
    .NFFT  (1024),
    .NTAPS (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .resync        (resync),
`ifdef PFB_WEIGHT_BYPASS_EN
    .weight_bypass (weight_bypass),
`endif
    .w_raddr       (w_raddr),
    .w_rdata       (w_rdata),
    .m_valid       (m_valid),
    .m_data        (m_data),
    .m_tap         (m_tap),
    .m_idx         (m_idx),
    .m_last        (m_last)
  );

  always #5 clk = ~clk;

  // Two-cycle synchronous SRAM model.
  logic signed [13:0] mem [4096];
  logic signed [13:0] rd1;
  always @(posedge clk) begin
    rd1     <= mem[w_raddr];
    w_rdata <= rd1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic signed [27:0] data;
    int                 tap;
    int                 idx;
    bit                 last;
    int                 cyc;
  } out_t;
  out_t outq[$];

  always @(negedge clk) begin
    if (m_valid === 1'b1) outq.push_back('{m_data, int'(m_tap), int'(m_idx), m_last, cyc});
  end

  typedef struct {
    logic signed [13:0] s;
    logic signed [13:0] w [4];
    logic signed [27:0] e [4];
  } vec_t;
  vec_t vecs [6];

  int n_checks = 0;
  int n_err    = 0;
  int acc_cyc  = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send_sample(input logic signed [13:0] d);
    int b = 0;
    while (s_ready !== 1'b1 && b < 50) begin
      @(posedge clk); #1;
      b++;
    end
    check("s_ready_before_send", s_ready, 1);
    s_valid = 1'b1;
    s_data  = d;
    acc_cyc = cyc;
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_outs(input int n, input int budget, input string name);
    int b = 0;
    while (outq.size() < n && b < budget) begin
      @(posedge clk); #1;
      b++;
    end
    repeat (6) @(posedge clk);
    #1;
    check(name, outq.size(), n);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
  endtask

  function automatic logic signed [13:0] sval(input int k);
    return 14'((k * 37) % 8192 - 4096);
  endfunction

  function automatic logic signed [13:0] wval(input int a);
    return 14'((a * 13) % 16384 - 8192);
  endfunction

  initial begin
    int n, first_acc, last_acc, b, bad, lastc, k, t, i;
    logic signed [27:0] e;
    s_valid = 1'b0;
    s_data  = '0;
    resync  = 1'b0;
    reset   = 1'b1;
`ifdef PFB_WEIGHT_BYPASS_EN
    weight_bypass = 1'b0;
`endif
    for (int a = 0; a < 4096; a++) mem[a] = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_tap", m_tap, 0);
    check("rst_m_idx", m_idx, 0);
    check("rst_m_last", m_last, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_w_raddr", w_raddr, 0);
    reset = 1'b0;
    #1;
    check("s_ready_after_release", s_ready, 1);

    vecs[0] = '{14'sd100,   '{14'sd1, 14'sd2, 14'sd3, 14'sd4},
                '{28'sd100, 28'sd200, 28'sd300, 28'sd400}};
    vecs[1] = '{-14'sd8192, '{-14'sd8192, -14'sd8192, -14'sd8192, -14'sd8192},
                '{28'sd67108864, 28'sd67108864, 28'sd67108864, 28'sd67108864}};
    vecs[2] = '{14'sd8191,  '{14'sd8191, -14'sd8192, -14'sd1, 14'sd0},
                '{28'sd67092481, -28'sd67100672, -28'sd8191, 28'sd0}};
    vecs[3] = '{-14'sd1,    '{14'sd1, -14'sd1, 14'sd8191, -14'sd8192},
                '{-28'sd1, 28'sd1, -28'sd8191, 28'sd8192}};
    vecs[4] = '{14'sd0,     '{14'sd5, 14'sd6, 14'sd7, 14'sd8},
                '{28'sd0, 28'sd0, 28'sd0, 28'sd0}};
    vecs[5] = '{14'sd1234,  '{-14'sd2, 14'sd3, 14'sd100, -14'sd100},
                '{-28'sd2468, 28'sd3702, 28'sd123400, -28'sd123400}};

    for (int v = 0; v < 6; v++) begin
      for (int tt = 0; tt < 4; tt++) mem[tt*1024 + v] = vecs[v].w[tt];
      outq.delete();
      send_sample(vecs[v].s);
      wait_outs(4, 40, "vec_out_count");
      for (int tt = 0; tt < 4; tt++) begin
        if (outq.size() > tt) begin
          check("vec_data", outq[tt].data, vecs[v].e[tt]);
          check("vec_tap", outq[tt].tap, tt);
          check("vec_idx", outq[tt].idx, v);
          check("vec_last", outq[tt].last, 0);
        end
      end
      if (outq.size() > 0) check("vec_latency", outq[0].cyc - acc_cyc, 4);
      if (v == 0) check("raddr_hold_idle", w_raddr, 12'd3072);
    end

    // Resync at tap 1 of the sample at idx 5.
    do_reset();
    for (int v = 0; v < 5; v++) begin
      outq.delete();
      send_sample(14'sd1);
      wait_outs(4, 40, "pre_resync_count");
    end
    mem[0*1024 + 5] = 14'sd2;
    mem[1*1024 + 5] = 14'sd3;
    mem[2*1024 + 5] = 14'sd4;
    mem[3*1024 + 5] = 14'sd5;
    outq.delete();
    send_sample(14'sd77);
    @(posedge clk); #1;
    check("raddr_tap1_idx5", w_raddr, 12'd1029);
    resync  = 1'b1;
    s_valid = 1'b1;
    s_data  = 14'sd9;
    #1;
    check("s_ready_during_resync", s_ready, 0);
    @(posedge clk); #1;
    resync  = 1'b0;
    s_valid = 1'b0;
    check("raddr_hold_after_resync", w_raddr, 12'd1029);
    repeat (8) @(posedge clk);
    #1;
    check("resync_out_count", outq.size(), 2);
    if (outq.size() >= 2) begin
      check("resync_data0", outq[0].data, 154);
      check("resync_data1", outq[1].data, 231);
      check("resync_tap1", outq[1].tap, 1);
      check("resync_idx", outq[0].idx, 5);
    end
    outq.delete();
    send_sample(14'sd10);
    wait_outs(4, 40, "post_resync_count");
    if (outq.size() == 4) begin
      check("post_resync_idx", outq[0].idx, 0);
      check("post_resync_data3", outq[3].data, 40);
    end

    // Reset while a back-to-back pair is in flight.
    do_reset();
    send_sample(14'sd50);
    send_sample(14'sd60);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("m_valid_before_reset", m_valid, 1);
    reset = 1'b1;
    #1;
    check("reset_m_valid", m_valid, 0);
    check("reset_m_data", m_data, 0);
    check("reset_s_ready", s_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    outq.delete();
    repeat (10) @(posedge clk);
    #1;
    check("no_out_after_reset", outq.size(), 0);
    send_sample(14'sd7);
    wait_outs(4, 40, "post_reset_count");
    if (outq.size() == 4) begin
      check("post_reset_idx", outq[0].idx, 0);
      check("post_reset_data0", outq[0].data, 7);
      check("post_reset_data3", outq[3].data, 28);
    end

`ifdef PFB_WEIGHT_BYPASS_EN
    do_reset();
    weight_bypass = 1'b1;
    outq.delete();
    send_sample(14'sd3);
    wait_outs(4, 40, "bypass_count");
    for (int tt = 0; tt < 4; tt++) begin
      if (outq.size() > tt) check("bypass_data", outq[tt].data, 24573);
    end
    weight_bypass = 1'b0;
`endif

    // Continuous stream of 2048 samples across two frames.
    do_reset();
    for (int a = 0; a < 4096; a++) mem[a] = wval(a);
    outq.delete();
    n = 0;
    b = 0;
    first_acc = 0;
    last_acc = 0;
    s_valid = 1'b1;
    s_data = sval(0);
    while (n < 2048 && b < 20000) begin
      k = (s_ready === 1'b1) ? 1 : 0;
      if (k == 1) begin
        if (n == 0) first_acc = cyc;
        last_acc = cyc;
      end
      @(posedge clk); #1;
      b++;
      if (k == 1) begin
        n++;
        s_data = sval(n);
      end
    end
    s_valid = 1'b0;
    check("stream_accepts", n, 2048);
    check("stream_duty", last_acc - first_acc, 2047 * 4);
    wait_outs(8192, 200, "stream_out_count");
    bad = 0;
    lastc = 0;
    for (int j = 0; j < outq.size(); j++) begin
      k = j / 4;
      t = j % 4;
      i = k % 1024;
      e = 28'(longint'(sval(k)) * longint'(mem[t*1024 + i]));
      if (outq[j].data !== e || outq[j].tap != t || outq[j].idx != i ||
          outq[j].cyc != outq[0].cyc + j || outq[j].last != (t == 3 && i == 1023)) bad++;
      if (outq[j].last) lastc++;
    end
    check("stream_bad_outputs", bad, 0);
    check("stream_last_count", lastc, 2);
    if (outq.size() > 4096) begin
      check("stream_last_at_4095", outq[4095].last, 1);
      check("stream_wrap_idx", outq[4096].idx, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
